imm_operand_stage: RTL and testbench
====================================

// Module: imm_operand_stage
// PURPOSE
//  Decode-to-execute pipeline stage; sits directly downstream of the immediate extender.
//  Takes a fetched instruction plus register-file read data and selects operand B from:
//   - zero-extended immediate
//   - sign-extended immediate
//   - lui-shifted immediate
//   - rt data
//  Computes destination register/write enable and the branch offset.
//  Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
//  Upstream stalls never drop an instruction.
// PARAMETERS
//  W        32   datapath width (operand, immediate result); only 32 supported
//  RST_VAL  0    value loaded into every data output/register on reset
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  flush        in   1   sync kill of all held entries (branch taken)
//  in_valid     in   1   upstream has an instruction
//  in_ready     out  1   stage can accept this cycle
//  instr        in   32  instruction word
//  rs_data      in   W   register file rs read
//  rt_data      in   W   register file rt read
//  out_valid    out  1   out_* fields valid
//  out_ready    in   1   downstream accepts this cycle
//  out_opa      out  W   rs_data passed through
//  out_opb      out  W   selected operand B
//  out_boff     out  W   sign_ext(imm)<<2 (branch offset)
//  out_rd       out  5   destination register
//  out_we       out  1   register write enable
//  out_illegal  out  1   unrecognised opcode
// BEHAVIOUR
//  Decoding is combinational at the input; results are captured into the holding registers.
//  Fields: op = instr[31:26], imm = instr[15:0].
//  Operand B select, by op:
//   - 0x00 R-type: opb = rt_data, rd = instr[15:11], we = 1
//   - 0x08-0x0B addi/addiu/slti/sltiu, 0x23 lw: opb = {{16{imm[15]}}, imm}, rd = instr[20:16], we = 1
//   - 0x0C-0x0E andi/ori/xori: opb = {16'h0, imm}, rd = instr[20:16], we = 1
//   - 0x0F lui: opb = {imm, 16'h0}, rd = instr[20:16], we = 1
//   - 0x2B sw: opb = sign-ext imm, we = 0, rd = 0
//   - 0x04/0x05 beq/bne: opb = rt_data, we = 0, rd = 0
//   - other: opb = 0, we = 0, rd = 0, illegal = 1
//  boff is always {{14{imm[15]}}, imm, 2'b00}; wraps mod 2^32.
//  Storage and ready:
//   - Two entries: OUT (drives out_*) and SKID.
//   - in_ready = !skid_valid (combinational, depends on state only).
//  Per cycle, with acc = in_valid & in_ready and pop = out_valid & out_ready:
//   - OUT empty or pop, SKID empty: acc loads OUT.
//   - OUT full, no pop: acc loads SKID.
//   - pop with SKID full: SKID moves to OUT, SKID empties (acc impossible, in_ready = 0).
//   - pop, no acc, SKID empty: out_valid -> 0.
//  Latency is 1 cycle from acc to out_valid when the stage is empty.
//  Throughput is 1/cycle while out_ready = 1.
//  out_* are held stable while out_valid & !out_ready.
//  flush = 1: both valids cleared next edge; same-cycle acc is discarded; flush dominates.
//  rst_n low (async):
//   - out_valid = 0, skid_valid = 0
//   - all out_* data = RST_VAL, out_we = 0, out_illegal = 0
//   - in_ready reads 1, but nothing is captured until rst_n is high at a clock edge.
//  Reset mid-handshake drops held entries; no partial state survives.
// TESTING
//  1. Reset, instr = 0x3C01_8001 (lui), in_valid=1, out_ready=1 -> next cycle out_opb = 0x8001_0000, out_rd = 1, we = 1.
//  2. ori imm 0x8000 -> out_opb = 0x0000_8000; addi imm 0x8000 -> out_opb = 0xFFFF_8000; beq imm 0xFFFF -> out_boff = 0xFFFF_FFFC.
//  3. Hold out_ready=0, send 3 instrs back-to-back -> 2 accepted, in_ready = 0 on 3rd; release out_ready -> outputs in order, none lost or duplicated.
//  4. Stream 100 random legal instrs with random out_ready -> scoreboard matches order and decode; out_* stable while stalled.
//  5. OUT and SKID full, flush=1 with in_valid=1 -> next cycle out_valid = 0, in_ready = 1, flushed instr never appears.
//  6. op = 0x3F -> out_illegal = 1, out_we = 0, out_opb = 0; assert rst_n low while out_valid=1 -> out_valid = 0 immediately.

Source files
------------

// File: rtl/imm_operand_stage.sv
// Decode-to-execute stage: selects operand B and computes the destination register and branch
// offset, then registers the result behind a valid/ready handshake with a 2-entry skid buffer.
module imm_operand_stage #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_opa,
    output logic [W-1:0] out_opb,
    output logic [W-1:0] out_boff,
    output logic [4:0]   out_rd,
    output logic         out_we,
    output logic         out_illegal
);

    typedef struct packed {
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [W-1:0] boff;
        logic [4:0]   rd;
        logic         we;
        logic         illegal;
    } entry_t;

    localparam entry_t RST_ENTRY = '{
        opa:     RST_VAL,
        opb:     RST_VAL,
        boff:    RST_VAL,
        rd:      RST_VAL[4:0],
        we:      1'b0,
        illegal: 1'b0
    };

    logic [5:0]  op;
    logic [15:0] imm;
    entry_t      dec;

    assign op  = instr[31:26];
    assign imm = instr[15:0];

    always_comb begin
        dec.opa     = rs_data;
        dec.opb     = '0;
        dec.boff    = {{(W-18){imm[15]}}, imm, 2'b00};
        dec.rd      = 5'd0;
        dec.we      = 1'b0;
        dec.illegal = 1'b0;
        case (op)
            6'h00: begin
                dec.opb = rt_data;
                dec.rd  = instr[15:11];
                dec.we  = 1'b1;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
                dec.opb = {{(W-16){imm[15]}}, imm};
                dec.rd  = instr[20:16];
                dec.we  = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec.opb = {{(W-16){1'b0}}, imm};
                dec.rd  = instr[20:16];
                dec.we  = 1'b1;
            end
            6'h0F: begin
                dec.opb = {imm, {(W-16){1'b0}}};
                dec.rd  = instr[20:16];
                dec.we  = 1'b1;
            end
            6'h2B: dec.opb = {{(W-16){imm[15]}}, imm};
            6'h04, 6'h05: dec.opb = rt_data;
            default: dec.illegal = 1'b1;
        endcase
    end

    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   acc, pop;

    assign in_ready = !skid_valid_q;
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Held data is left in place; only the valids matter after a kill.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (pop) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || pop) begin
            out_valid_d = acc;
            if (acc) begin
                out_d = dec;
            end
        end else if (acc) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= RST_ENTRY;
            skid_q       <= RST_ENTRY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opa     = out_q.opa;
    assign out_opb     = out_q.opb;
    assign out_boff    = out_q.boff;
    assign out_rd      = out_q.rd;
    assign out_we      = out_q.we;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_operand_stage.sv
// Directed and randomized self-checking bench for imm_operand_stage.
module tb_imm_operand_stage;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [W-1:0] boff;
        logic [4:0]   rd;
        logic         we;
        logic         illegal;
    } ent_t;

    logic         clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  instr;
    logic [W-1:0] rs_data, rt_data, out_opa, out_opb, out_boff;
    logic [4:0]   out_rd;
    logic         out_we, out_illegal;

    int checks = 0;
    int errors = 0;

    imm_operand_stage #(.W(W), .RST_VAL('0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opa     (out_opa),
        .out_opb     (out_opb),
        .out_boff    (out_boff),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Reference decode used by the random stream scoreboard.
    function automatic ent_t model(input logic [31:0] i, input logic [W-1:0] rs,
                                   input logic [W-1:0] rt);
        ent_t e;
        logic [31:0] sx, zx;
        sx = {{16{i[15]}}, i[15:0]};
        zx = {16'h0, i[15:0]};
        e = '{opa: rs, opb: '0, boff: sx << 2, rd: 5'd0, we: 1'b0, illegal: 1'b0};
        case (i[31:26])
            6'h00:                             begin e.opb = rt; e.rd = i[15:11]; e.we = 1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin e.opb = sx; e.rd = i[20:16]; e.we = 1; end
            6'h0C, 6'h0D, 6'h0E:               begin e.opb = zx; e.rd = i[20:16]; e.we = 1; end
            6'h0F: begin e.opb = {i[15:0], 16'h0}; e.rd = i[20:16]; e.we = 1; end
            6'h2B:                             e.opb = sx;
            6'h04, 6'h05:                      e.opb = rt;
            default:                           e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic push(input logic [31:0] i, input logic [W-1:0] rs, input logic [W-1:0] rt);
        @(negedge clk);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h3C01_8001;
        rs_data   = '0;
        rt_data   = '0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_opb, out_boff, out_we, out_illegal} !== {2'b01, 66'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%b rdy=%b opb=%h we=%b ill=%b", out_valid, in_ready,
                     out_opb, out_we, out_illegal);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture got %b exp 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_lui();
        push(32'h3C01_8001, 32'h1111_2222, 32'h3333_4444);
        checks++;
        if ({out_valid, out_opa, out_opb, out_boff, out_rd, out_we}
            !== {1'b1, 32'h1111_2222, 32'h8001_0000, 32'hFFFE_0004, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL lui got v=%b opa=%h opb=%h boff=%h rd=%0d we=%b", out_valid, out_opa,
                     out_opb, out_boff, out_rd, out_we);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lui_pop got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_imm_forms();
        logic [31:0] iv  [6] = '{32'h3402_8000, 32'h2003_8000, 32'h1000_FFFF,
                                 32'h0000_5820, 32'hAC05_FFF0, 32'h8C06_0010};
        logic [31:0] opb [6] = '{32'h0000_8000, 32'hFFFF_8000, 32'hA5A5_0F0F,
                                 32'hA5A5_0F0F, 32'hFFFF_FFF0, 32'h0000_0010};
        logic [31:0] bo  [6] = '{32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFF_FFFC,
                                 32'h0001_6080, 32'hFFFF_FFC0, 32'h0000_0040};
        logic [4:0]  rd  [6] = '{5'd2, 5'd3, 5'd0, 5'd11, 5'd0, 5'd6};
        logic        we  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            push(iv[k], 32'h0, 32'hA5A5_0F0F);
            checks++;
            if ({out_valid, out_opb, out_boff, out_rd, out_we, out_illegal}
                !== {1'b1, opb[k], bo[k], rd[k], we[k], 1'b0}) begin
                errors++;
                $display("FAIL imm_form[%0d] got opb=%h boff=%h rd=%0d we=%b ill=%b exp opb=%h boff=%h rd=%0d we=%b",
                         k, out_opb, out_boff, out_rd, out_we, out_illegal, opb[k], bo[k], rd[k],
                         we[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [3] = '{32'h2001_0001, 32'h3402_0002, 32'h3C03_0003};
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr    = seq[k];
            in_valid = 1'b1;
            checks++;
            if (in_ready !== (k < 2)) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d] got %b exp %b", k, in_ready, k < 2);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_opb} !== {2'b10, 32'h0000_0001}) begin
            errors++;
            $display("FAIL b2b_stall got v=%b rdy=%b opb=%h exp 1 0 00000001", out_valid, in_ready,
                     out_opb);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_opb} !== {2'b11, 32'h0000_0002}) begin
            errors++;
            $display("FAIL b2b_second got v=%b rdy=%b opb=%h exp 1 1 00000002", out_valid,
                     in_ready, out_opb);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained got v=%b opb=%h exp v=0", out_valid, out_opb);
        end
    endtask

    task automatic test_random_stream();
        ent_t        q[$];
        ent_t        got, prev;
        logic        prev_stall = 1'b0;
        logic        acc, pop;
        int          sent = 0;
        logic [5:0]  ops [13] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h0C, 6'h0D,
                                  6'h0E, 6'h0F, 6'h2B, 6'h04, 6'h05};
        for (int cyc = 0; cyc < 3000 && (sent < 100 || q.size() > 0); cyc++) begin
            @(negedge clk);
            got = '{opa: out_opa, opb: out_opb, boff: out_boff, rd: out_rd, we: out_we,
                    illegal: out_illegal};
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL stream_flags cyc %0d got v=%b rdy=%b occ=%0d", cyc, out_valid,
                         in_ready, q.size());
            end else if (q.size() > 0 && got !== q[0]) begin
                errors++;
                $display("FAIL stream_data cyc %0d got %h exp %h", cyc, got, q[0]);
            end else if (prev_stall && got !== prev) begin
                errors++;
                $display("FAIL stream_stable cyc %0d got %h exp %h", cyc, got, prev);
            end
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            instr     = {ops[$urandom_range(0, 12)], 26'($urandom)};
            rs_data   = $urandom;
            rt_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            acc        = in_valid && (q.size() < 2);
            pop        = (q.size() > 0) && out_ready;
            prev_stall = (q.size() > 0) && !out_ready;
            prev       = got;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(instr, rs_data, rt_data));
                sent++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 100 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_done got sent=%0d left=%0d v=%b exp 100 0 0", sent, q.size(),
                     out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(32'h2001_0011, 32'h0, 32'h0);
        push(32'h2001_0022, 32'h0, 32'h0);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_full got v=%b rdy=%b exp 1 0", out_valid, in_ready);
        end
        instr    = 32'h2001_0033;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full_clear got v=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
        // Empty stage: the accepted instruction in the flush cycle must be discarded.
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_same_cycle got v=%b rdy=%b opb=%h exp 0 1", out_valid, in_ready,
                     out_opb);
        end
    endtask

    task automatic test_illegal_reset();
        out_ready = 1'b0;
        push(32'hFC00_1234, 32'h5, 32'h6);
        checks++;
        if ({out_valid, out_illegal, out_we, out_opb, out_rd, out_boff}
            !== {3'b110, 32'h0, 5'd0, 32'h0000_48D0}) begin
            errors++;
            $display("FAIL illegal got v=%b ill=%b we=%b opb=%h rd=%0d boff=%h", out_valid,
                     out_illegal, out_we, out_opb, out_rd, out_boff);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_illegal, out_opa, out_boff} !== {3'b010, 64'h0}) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b ill=%b opa=%h boff=%h", out_valid,
                     in_ready, out_illegal, out_opa, out_boff);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop got v=%b exp 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_lui();
        test_imm_forms();
        test_back_to_back();
        test_random_stream();
        test_flush();
        test_illegal_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
